// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes,
// controller state encoding and RAM byte-write-enable masks.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] WEN_NONE = 4'b0000;
    localparam logic [3:0] WEN_BYTE = 4'b0001;
    localparam logic [3:0] WEN_LO   = 4'b0011;
    localparam logic [3:0] WEN_HI   = 4'b1100;
    localparam logic [3:0] WEN_ALL  = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store write enables and replicated store
// data, load extraction with sign/zero extension, and alignment fault detect.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wen,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and form enables/data for the access size.
    always_comb begin
        byte_sel   = rdata[8*lane +: 8];
        half_sel   = lane[1] ? rdata[31:16] : rdata[15:0];
        wen        = WEN_NONE;
        lane_wdata = wdata;
        load_data  = rdata;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                wen        = WEN_BYTE << lane;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = load_unsigned ? {24'd0, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                misaligned = lane[0];
                wen        = lane[1] ? WEN_HI : WEN_LO;
                lane_wdata = {2{wdata[15:0]}};
                load_data  = load_unsigned ? {16'd0, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                misaligned = (lane != 2'd0);
                wen        = WEN_ALL;
            end
            default: begin
                misaligned = 1'b1;
                load_data  = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: accepts one request, runs a single RAM access
// (plus one wait cycle for registered-read RAMs), and returns a response or
// an address-error exception to writeback under valid/ready.
//
// state  | meaning
// IDLE   | ready for a new request
// ACCESS | RAM enabled; stores commit on the closing edge
// WAIT   | registered-read RAM: hold address, capture rdata at the end
// RESP   | response valid, held until resp_ready
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 0    // 0 = combinational read, 1 = registered read
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_is_load,
    output logic              resp_exc,
    output logic [31:0]       resp_badvaddr,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t      state;
    logic        q_we;
    logic [1:0]  q_size;
    logic        q_unsigned;
    logic [1:0]  q_lane;
    logic        ram_en_q;
    logic [3:0]  ram_wen_q;

    logic        in_idle;
    logic [1:0]  al_size;
    logic        al_unsigned;
    logic [1:0]  al_lane;
    logic [3:0]  al_wen;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misaligned;

    // One aligner serves both phases: incoming request while idle (store
    // lanes, fault check), latched request afterwards (load extraction).
    assign in_idle     = (state == ST_IDLE);
    assign al_size     = in_idle ? req_size     : q_size;
    assign al_unsigned = in_idle ? req_unsigned : q_unsigned;
    assign al_lane     = in_idle ? req_addr[1:0] : q_lane;

    mem_lane_align u_align (
        .size          (al_size),
        .load_unsigned (al_unsigned),
        .lane          (al_lane),
        .wdata         (req_wdata),
        .rdata         (ram_rdata),
        .wen           (al_wen),
        .lane_wdata    (al_wdata),
        .load_data     (al_load),
        .misaligned    (al_misaligned)
    );

    // Reset gates the RAM strobes immediately so an in-flight store cannot commit.
    assign ram_en  = ram_en_q & ~rst;
    assign ram_wen = ram_wen_q & {4{~rst}};

    // Controller FSM with all handshake, RAM and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_wen_q     <= WEN_NONE;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            resp_rdata    <= '0;
            resp_rd       <= '0;
            resp_is_load  <= 1'b0;
            resp_exc      <= 1'b0;
            resp_badvaddr <= '0;
            q_we          <= 1'b0;
            q_size        <= SZ_BYTE;
            q_unsigned    <= 1'b0;
            q_lane        <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        q_we         <= req_we;
                        q_size       <= req_size;
                        q_unsigned   <= req_unsigned;
                        q_lane       <= req_addr[1:0];
                        resp_rd      <= req_rd;
                        resp_is_load <= ~req_we;
                        req_ready    <= 1'b0;
                        if (al_misaligned) begin
                            state         <= ST_RESP;
                            resp_valid    <= 1'b1;
                            resp_exc      <= 1'b1;
                            resp_badvaddr <= req_addr;
                            resp_rdata    <= '0;
                        end else begin
                            state     <= ST_ACCESS;
                            ram_en_q  <= 1'b1;
                            ram_wen_q <= req_we ? al_wen : WEN_NONE;
                            ram_addr  <= req_addr[ADDR_W+1:2];
                            if (req_we) begin
                                ram_wdata <= al_wdata;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    ram_wen_q     <= WEN_NONE;
                    resp_exc      <= 1'b0;
                    resp_badvaddr <= '0;
                    if (q_we || RD_LATENCY == 0) begin
                        state      <= ST_RESP;
                        ram_en_q   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= q_we ? 32'd0 : al_load;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state      <= ST_RESP;
                    ram_en_q   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= al_load;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: one instance with a combinational-read RAM
// (index 0) and one with a registered-read RAM (index 1).
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        is_load;
        logic        exc;
        logic [31:0] badvaddr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]       resp_valid, resp_ready, resp_is_load, resp_exc, ram_en;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_addr, req_wdata, resp_rdata, resp_badvaddr;
    logic [1:0][31:0] ram_wdata, ram_rdata;
    logic [1:0][4:0]  req_rd, resp_rd;
    logic [1:0][3:0]  ram_wen;
    logic [1:0][9:0]  ram_addr;

    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    logic [31:0] rd1_q;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mem_access_unit #(.ADDR_W(10), .RD_LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_rd(req_rd[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_rd(resp_rd[0]), .resp_is_load(resp_is_load[0]), .resp_exc(resp_exc[0]),
        .resp_badvaddr(resp_badvaddr[0]),
        .ram_en(ram_en[0]), .ram_wen(ram_wen[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
    );

    mem_access_unit #(.ADDR_W(10), .RD_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_rd(req_rd[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_rd(resp_rd[1]), .resp_is_load(resp_is_load[1]), .resp_exc(resp_exc[1]),
        .resp_badvaddr(resp_badvaddr[1]),
        .ram_en(ram_en[1]), .ram_wen(ram_wen[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
    );

    // RAM models: instance 0 reads combinationally, instance 1 through a register.
    assign ram_rdata[0] = mem0[ram_addr[0]];
    assign ram_rdata[1] = rd1_q;

    always @(posedge clk) begin
        if (ram_en[1]) rd1_q <= mem1[ram_addr[1]];
        for (int b = 0; b < 4; b++) begin
            if (ram_en[0] && ram_wen[0][b]) mem0[ram_addr[0]][8*b +: 8] = ram_wdata[0][8*b +: 8];
            if (ram_en[1] && ram_wen[1][b]) mem1[ram_addr[1]][8*b +: 8] = ram_wdata[1][8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Scoreboard: every completed response is compared with the oldest expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst && resp_valid[i] && resp_ready[i]) begin
                exp_t e;
                int   qs;
                qs = (i == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    chk("sb_empty", 32'(qs), 32'd1);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk("resp_rdata",    resp_rdata[i],           e.rdata);
                    chk("resp_rd",       32'(resp_rd[i]),         32'(e.rd));
                    chk("resp_is_load",  32'(resp_is_load[i]),    32'(e.is_load));
                    chk("resp_exc",      32'(resp_exc[i]),        32'(e.exc));
                    chk("resp_badvaddr", resp_badvaddr[i],        e.badvaddr);
                end
            end
        end
    end

    // Issue one request; lat is the expected edge count from acceptance to
    // resp_valid (1 means an address fault). Called just after a posedge.
    task automatic do_req(input int i, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input int lat, input logic [3:0] wen, input logic [9:0] ea,
                          input logic [31:0] ewd, input logic [31:0] erd);
        exp_t e;
        int   got;
        bit   acc;
        e.rdata    = erd;
        e.rd       = rd;
        e.is_load  = ~we;
        e.exc      = (lat == 1);
        e.badvaddr = (lat == 1) ? addr : 32'd0;
        push_exp(i, e);
        req_valid[i] = 1'b1; req_we[i] = we; req_size[i] = sz; req_unsigned[i] = uns;
        req_addr[i] = addr; req_wdata[i] = wdata; req_rd[i] = rd;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            if (req_ready[i]) acc = 1'b1;
        end
        if (!acc) chk("accept_timeout", 32'(req_ready[i]), 32'd1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        got = 0;
        for (int n = 1; n <= 8 && got == 0; n++) begin
            @(negedge clk);
            if (lat == 1) begin
                chk("fault_ram_en", 32'(ram_en[i]), 32'd0);
            end else if (n < lat) begin
                chk("ram_en",   32'(ram_en[i]),   32'd1);
                chk("ram_addr", 32'(ram_addr[i]), 32'(ea));
                chk("ram_wen",  32'(ram_wen[i]),  (n == 1) ? 32'(wen) : 32'd0);
                if (we && n == 1) chk("ram_wdata", ram_wdata[i], ewd);
            end
            if (resp_valid[i]) begin
                got = n;
                chk("resp_ram_en", 32'(ram_en[i]), 32'd0);
            end
        end
        chk("latency", 32'(got), 32'(lat));
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        int   got;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   got;
        rst = 1'b1;
        resp_ready = 2'b11;
        req_valid = '0; req_we = '0; req_unsigned = '0; req_size = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        for (int a = 0; a < 1024; a++) begin
            mem0[a] = 32'd0;
            mem1[a] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready",     32'(req_ready[i]),    32'd1);
            chk("rst_resp_valid",    32'(resp_valid[i]),   32'd0);
            chk("rst_ram_en",        32'(ram_en[i]),       32'd0);
            chk("rst_ram_wen",       32'(ram_wen[i]),      32'd0);
            chk("rst_ram_addr",      32'(ram_addr[i]),     32'd0);
            chk("rst_ram_wdata",     ram_wdata[i],         32'd0);
            chk("rst_resp_rdata",    resp_rdata[i],        32'd0);
            chk("rst_resp_rd",       32'(resp_rd[i]),      32'd0);
            chk("rst_resp_is_load",  32'(resp_is_load[i]), 32'd0);
            chk("rst_resp_exc",      32'(resp_exc[i]),     32'd0);
            chk("rst_resp_badvaddr", resp_badvaddr[i],     32'd0);
        end
        @(posedge clk); #1;

        // Combinational-read instance.
        do_req(0, 1, 2'd2, 0, 32'h8,  32'h1122_3344, 5'd1, 2, 4'b1111, 10'd2, 32'h1122_3344, 32'h0);
        do_req(0, 0, 2'd2, 0, 32'h8,  32'h0,         5'd2, 2, 4'b0000, 10'd2, 32'h0, 32'h1122_3344);
        do_req(0, 1, 2'd0, 0, 32'hD,  32'h0000_00F0, 5'd3, 2, 4'b0010, 10'd3, 32'hF0F0_F0F0, 32'h0);
        chk("mem_sb", mem0[3], 32'h0000_F000);
        mem0[3] = 32'h1122_F044;
        do_req(0, 0, 2'd0, 0, 32'hD,  32'h0, 5'd4, 2, 4'b0000, 10'd3, 32'h0, 32'hFFFF_FFF0);
        do_req(0, 0, 2'd0, 1, 32'hD,  32'h0, 5'd5, 2, 4'b0000, 10'd3, 32'h0, 32'h0000_00F0);
        mem0[1] = 32'h8001_0000;
        do_req(0, 0, 2'd1, 0, 32'h6,  32'h0, 5'd6, 2, 4'b0000, 10'd1, 32'h0, 32'hFFFF_8001);
        do_req(0, 0, 2'd1, 1, 32'h6,  32'h0, 5'd7, 2, 4'b0000, 10'd1, 32'h0, 32'h0000_8001);
        do_req(0, 0, 2'd2, 0, 32'h6,  32'h0, 5'd8, 1, 4'b0000, 10'd0, 32'h0, 32'h0);
        do_req(0, 0, 2'd3, 0, 32'h6,  32'h0, 5'd9, 1, 4'b0000, 10'd0, 32'h0, 32'h0);
        do_req(0, 1, 2'd1, 0, 32'h1,  32'h1234, 5'd10, 1, 4'b0000, 10'd0, 32'h0, 32'h0);
        do_req(0, 1, 2'd1, 0, 32'h2,  32'h0000_ABCD, 5'd11, 2, 4'b1100, 10'd0, 32'hABCD_ABCD, 32'h0);
        chk("mem_sh", mem0[0], 32'hABCD_0000);
        do_req(0, 1, 2'd2, 0, 32'h1000_0014, 32'h0000_0055, 5'd12, 2, 4'b1111, 10'd5, 32'h0000_0055, 32'h0);
        chk("mem_alias", mem0[5], 32'h0000_0055);

        // Backpressure: response held while a second request waits.
        resp_ready[0] = 1'b0;
        e.rdata = 32'h1122_3344; e.rd = 5'd13; e.is_load = 1'b1; e.exc = 1'b0; e.badvaddr = 32'h0;
        push_exp(0, e);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
        req_addr[0] = 32'h8; req_rd[0] = 5'd13;
        @(negedge clk);
        chk("bp_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        e.rdata = 32'h0000_00F0; e.rd = 5'd14;
        push_exp(0, e);
        req_size[0] = 2'd0; req_unsigned[0] = 1'b1; req_addr[0] = 32'hD; req_rd[0] = 5'd14;
        got = 0;
        for (int n = 0; n < 8 && got == 0; n++) begin
            @(negedge clk);
            if (resp_valid[0]) got = 1;
        end
        chk("bp_resp_seen", 32'(got), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid",     32'(resp_valid[0]), 32'd1);
            chk("bp_rdata",     resp_rdata[0],      32'h1122_3344);
            chk("bp_rd",        32'(resp_rd[0]),    32'd13);
            chk("bp_req_ready", 32'(req_ready[0]),  32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_idle_ready", 32'(req_ready[0]),  32'd1);
        chk("bp_idle_valid", 32'(resp_valid[0]), 32'd0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("bp_accepted", 32'(req_ready[0]), 32'd0);
        got = 0;
        for (int n = 0; n < 8 && got == 0; n++) begin
            if (resp_valid[0]) got = 1;
            else @(negedge clk);
        end
        chk("bp_second_resp", 32'(resp_valid[0]), 32'd1);
        @(posedge clk); #1;

        // Reset during the ACCESS cycle of a store.
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'd2; req_unsigned[0] = 1'b0;
        req_addr[0] = 32'h10; req_wdata[0] = 32'hDEAD_BEEF; req_rd[0] = 5'd15;
        @(negedge clk);
        chk("rs_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rs_ram_en",  32'(ram_en[0]),  32'd0);
        chk("rs_ram_wen", 32'(ram_wen[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rs_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("rs_req_ready",  32'(req_ready[0]),  32'd1);
        chk("rs_mem",        mem0[4],            32'h0);
        @(posedge clk); #1;

        // Registered-read instance.
        do_req(1, 1, 2'd2, 0, 32'h8, 32'h1122_3344, 5'd1, 2, 4'b1111, 10'd2, 32'h1122_3344, 32'h0);
        do_req(1, 0, 2'd2, 0, 32'h8, 32'h0, 5'd2, 3, 4'b0000, 10'd2, 32'h0, 32'h1122_3344);
        mem1[3] = 32'h1122_F044;
        do_req(1, 0, 2'd0, 0, 32'hD, 32'h0, 5'd3, 3, 4'b0000, 10'd3, 32'h0, 32'hFFFF_FFF0);
        do_req(1, 0, 2'd0, 1, 32'hD, 32'h0, 5'd4, 3, 4'b0000, 10'd3, 32'h0, 32'h0000_00F0);
        mem1[1] = 32'h8001_0000;
        do_req(1, 0, 2'd1, 0, 32'h6, 32'h0, 5'd5, 3, 4'b0000, 10'd1, 32'h0, 32'hFFFF_8001);
        do_req(1, 0, 2'd1, 1, 32'h6, 32'h0, 5'd6, 3, 4'b0000, 10'd1, 32'h0, 32'h0000_8001);
        do_req(1, 0, 2'd2, 0, 32'h6, 32'h0, 5'd7, 1, 4'b0000, 10'd0, 32'h0, 32'h0);

        repeat (2) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store unit for the pipeline CPU MEM stage.
- Accepts one byte-addressed load/store request from the pipeline and drives the data RAM's en/wen/addr/wdata port.
- Captures and aligns rdata, with sign or zero extension for loads.
- Returns a completion response, or an address-error exception, to writeback under a valid/ready handshake.

Parameters:
- ADDR_W, 10, RAM word-address width; RAM word address = req_addr[ADDR_W+1:2].
- RD_LATENCY, 0, RAM read latency in cycles. 0 = combinational read; 1 = registered read. Only 0 and 1 are legal.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  input  1  zero-extend load (lbu/lhu)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- req_rd  input  5  destination register tag, passed through
- resp_valid  output  1  response present
- resp_ready  input  1  writeback accepts response
- resp_rdata  output  32  extended load data; 0 for stores and exceptions
- resp_rd  output  5  tag of the completed request
- resp_is_load  output  1  completed request was a load
- resp_exc  output  1  address error (misaligned or size 3)
- resp_badvaddr  output  32  req_addr of the faulting request; 0 otherwise
- ram_en  output  1  RAM access enable
- ram_wen  output  4  RAM byte write enables
- ram_addr  output  ADDR_W  RAM word address
- ram_wdata  output  32  lane-replicated store data
- ram_rdata  input  32  RAM read data

Behaviour:
- Reset values: state IDLE. req_ready=1, resp_valid=0, ram_en=0, ram_wen=0. ram_addr, ram_wdata, resp_rdata, resp_rd, resp_is_load, resp_exc and resp_badvaddr are all 0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- req_ready=1 only in IDLE.
- A request is accepted when req_valid && req_ready. All req_* fields are latched into the request register on that edge.
- IDLE -> RESP on acceptance if the request is faulting. Faulting means: size 3, half with addr[0]=1, or word with addr[1:0]!=0. No RAM access occurs.
- IDLE -> ACCESS on acceptance otherwise.
- ACCESS cycle drives, from registers:
  - ram_en=1 and ram_addr=addr[ADDR_W+1:2].
  - Stores only: ram_wen and ram_wdata. The store commits on the edge that ends ACCESS.
- ACCESS -> RESP if the request is a store or RD_LATENCY=0; in the RD_LATENCY=0 load case, ram_rdata is captured at the end of ACCESS.
- ACCESS -> WAIT if the request is a load and RD_LATENCY=1. WAIT keeps ram_en=1 and ram_addr stable, captures ram_rdata at its end, then goes to RESP.
- RESP: resp_valid=1 and all resp_* fields are held stable until resp_ready. RESP -> IDLE on resp_ready. There is no same-cycle re-accept, so throughput is at most one request per 3 cycles (4 with RD_LATENCY=1).
- Latency from acceptance edge to resp_valid:
  - 2 cycles: loads and stores with RD_LATENCY=0.
  - 3 cycles: loads with RD_LATENCY=1.
  - 1 cycle: faults.
- Byte lanes are little-endian; lane = addr[1:0].
  - Byte: wen = 4'b0001 << lane; wdata = {4{wdata[7:0]}}.
  - Half: wen = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - Word: wen = 4'b1111; wdata unchanged.
- Load extract:
  - Byte: rdata[8*lane+7 : 8*lane].
  - Half: rdata[16*addr[1]+15 : 16*addr[1]].
  - Sign-extend unless req_unsigned; word ignores req_unsigned.
- Address bits above ADDR_W+1 are ignored; addresses alias with no exception.
- When not in ACCESS/WAIT: ram_en=0 and ram_wen=0. ram_wen is always 0 for loads.
- Reset mid-operation: ram_en and ram_wen are gated with !rst combinationally, so a store in ACCESS during a reset cycle does not write. The next edge returns to IDLE and discards any pending response.
- If resp_ready is already high when RESP is entered, the response completes in that single cycle.

Decomposition:
- Shared package mem_access_pkg holds:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - the state encoding;
  - localparams for wen masks.
- One combinational sub-module, mem_lane_align: inputs size, unsigned, addr[1:0], wdata, rdata; outputs wen, lane_wdata, load_data, misaligned. It is instantiated once.

Test Plan:
- sw addr=0x0000_0008 data=0x1122_3344, then lw same address (RD_LATENCY=0):
  - ACCESS cycle shows ram_en=1, ram_wen=4'b1111, ram_addr=2.
  - Load returns resp_rdata=0x1122_3344 two cycles after acceptance.
- sb addr=0x0000_000D data=0x0000_00F0 -> ram_wen=4'b0010, ram_wdata=0xF0F0_F0F0. Then with the RAM word at address 3 = 0x1122_F044:
  - lb addr 0xD -> 0xFFFF_FFF0;
  - lbu -> 0x0000_00F0.
- lh addr=0x0000_0006 with RAM word 1 = 0x8001_0000 -> 0xFFFF_8001; lhu -> 0x0000_8001.
- lw addr=0x0000_0006 -> resp_exc=1 and resp_badvaddr=0x6 one cycle after acceptance, with no ram_en pulse. req_size=3 gives the same response.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_* stable and req_ready=0; a pending req_valid is not accepted until one cycle after the resp_ready handshake.
- Assert rst during the ACCESS cycle of sw -> ram_en=0 and RAM unchanged; the next cycle is IDLE with resp_valid=0. Repeat both directed loads with RD_LATENCY=1 and check the extra WAIT cycle.
